// File: rtl/conv_dr_pkg.sv
// Shared definitions for the clocked-to-dual-rail path: FSM states, spacer value
// and the single-rail to dual-rail encoder used by the sender and decoder blocks.
package conv_dr_pkg;

    typedef enum logic [1:0] {
        REPOUSO = 2'd0,
        DADO    = 2'd1,
        NULO    = 2'd2
    } estado_t;

    localparam logic [7:0] DR_ESPACADOR = 8'h00;

    // Bit i drives rail 2i+1 (true) when 1, rail 2i (false) when 0.
    function automatic logic [7:0] cod_dual_rail(input logic [3:0] dado);
        logic [7:0] rails;
        rails = '0;
        for (int i = 0; i < 4; i++) begin
            rails[2*i+1] = dado[i];
            rails[2*i]   = ~dado[i];
        end
        return rails;
    endfunction

endpackage

// File: rtl/conv_sinc_dr_4bits_sinc_ack.sv
// N-stage synchroniser for the asynchronous completion acknowledge.
module sinc_ack #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] estagio_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estagio_q <= '0;
        end else begin
            estagio_q <= {estagio_q[N-2:0], d_i};
        end
    end

    assign q_o = estagio_q[N-1];

endmodule

// File: rtl/conv_sinc_dr_4bits.sv
// Clocked-to-dual-rail sender: FIFO-buffered 4-bit words out as four-phase RZ codewords.
// Optional handshake timeout flag enabled by defining CONV_DR_TIMEOUT_EN.
module conv_sinc_dr_4bits
    import conv_dr_pkg::*;
#(
    parameter int PROF_FIFO      = 2,
    parameter int SYNC_ESTAGIOS  = 2,
    parameter int TIMEOUT_CICLOS = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dado_in,
    input  logic       valido_in,
    output logic       pronto_out,
    output logic [7:0] dr_out,
    output logic       hab_out,
    input  logic       ack_in,
    output logic       ocupado,
    output logic       erro_timeout
);

    localparam int AW = $clog2(PROF_FIFO);
    localparam int CW = AW + 1;

    if (PROF_FIFO < 2 || (PROF_FIFO & (PROF_FIFO - 1)) != 0) begin : g_chk_fifo
        $error("PROF_FIFO must be a power of two >= 2");
    end
    if (SYNC_ESTAGIOS < 2) begin : g_chk_sync
        $error("SYNC_ESTAGIOS must be >= 2");
    end
    if (TIMEOUT_CICLOS < 1) begin : g_chk_timeout
        $error("TIMEOUT_CICLOS must be >= 1");
    end

    logic          ack_s;
    logic [3:0]    mem_q [PROF_FIFO];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    estado_t       state_q, state_d;
    logic [7:0]    dr_q, dr_d;
    logic          hab_q, hab_d;
    logic          ocupado_q, ocupado_d;

    sinc_ack #(.N(SYNC_ESTAGIOS)) u_sinc_ack (
        .clk (clk),
        .rst (rst),
        .d_i (ack_in),
        .q_o (ack_s)
    );

    // A pop never frees a slot for a same-cycle push: acceptance looks only at count_q.
    assign pronto_out = (count_q < CW'(PROF_FIFO));
    assign push       = valido_in & pronto_out;
    assign count_d    = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dado_in;
        end
    end

    always_comb begin
        state_d = state_q;
        dr_d    = dr_q;
        hab_d   = hab_q;
        pop     = 1'b0;
        case (state_q)
            REPOUSO: begin
                dr_d  = DR_ESPACADOR;
                hab_d = 1'b0;
                // A high ack_s here is stale; wait for it to fall before sending.
                if (count_q != '0 && !ack_s) begin
                    pop     = 1'b1;
                    dr_d    = cod_dual_rail(mem_q[rd_ptr_q]);
                    hab_d   = 1'b1;
                    state_d = DADO;
                end
            end
            DADO: begin
                if (ack_s) begin
                    dr_d    = DR_ESPACADOR;
                    hab_d   = 1'b0;
                    state_d = NULO;
                end
            end
            NULO: begin
                if (!ack_s) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        dr_d    = cod_dual_rail(mem_q[rd_ptr_q]);
                        hab_d   = 1'b1;
                        state_d = DADO;
                    end else begin
                        state_d = REPOUSO;
                    end
                end
            end
            default: begin
                dr_d    = DR_ESPACADOR;
                hab_d   = 1'b0;
                state_d = REPOUSO;
            end
        endcase
        ocupado_d = (state_d != REPOUSO) || (count_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= REPOUSO;
            dr_q      <= DR_ESPACADOR;
            hab_q     <= 1'b0;
            ocupado_q <= 1'b0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            dr_q      <= dr_d;
            hab_q     <= hab_d;
            ocupado_q <= ocupado_d;
            count_q   <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    assign dr_out  = dr_q;
    assign hab_out = hab_q;
    assign ocupado = ocupado_q;

`ifdef CONV_DR_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CICLOS + 1) > 8) ? $clog2(TIMEOUT_CICLOS + 1) : 8;

    logic [TW-1:0] cnt_q, cnt_d;
    logic          erro_q, erro_d;

    // Counter restarts on every state entry and saturates at the limit.
    always_comb begin
        cnt_d  = cnt_q;
        erro_d = erro_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != REPOUSO && cnt_q != TW'(TIMEOUT_CICLOS)) begin
            cnt_d = cnt_q + TW'(1);
        end
        if (cnt_d == TW'(TIMEOUT_CICLOS)) begin
            erro_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            erro_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            erro_q <= erro_d;
        end
    end

    assign erro_timeout = erro_q;
`else
    assign erro_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_conv_sinc_dr_4bits.sv
// Directed self-checking bench for conv_sinc_dr_4bits (PROF_FIFO=2, SYNC_ESTAGIOS=2, TIMEOUT_CICLOS=16).
module tb_conv_sinc_dr_4bits;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dado_in;
    logic       valido_in;
    logic       pronto_out;
    logic [7:0] dr_out;
    logic       hab_out;
    logic       ack_in;
    logic       ocupado;
    logic       erro_timeout;

    int total = 0;
    int bad   = 0;

    logic [7:0] seq_q[$];
    logic       ds_ok;
    logic [7:0] dr_prev = 8'h00;

    always #5 clk = ~clk;

    conv_sinc_dr_4bits #(
        .PROF_FIFO      (2),
        .SYNC_ESTAGIOS  (2),
        .TIMEOUT_CICLOS (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dado_in      (dado_in),
        .valido_in    (valido_in),
        .pronto_out   (pronto_out),
        .dr_out       (dr_out),
        .hab_out      (hab_out),
        .ack_in       (ack_in),
        .ocupado      (ocupado),
        .erro_timeout (erro_timeout)
    );

    // Protocol watch: never codeword->codeword, never an 11 rail pair.
    always @(dr_out) begin
        total++;
        if (dr_prev !== 8'h00 && dr_out !== 8'h00) begin
            bad++;
            $display("FAIL cw_to_cw: got %h after %h, required spacer in between", dr_out, dr_prev);
        end
        for (int i = 0; i < 4; i++) begin
            if (dr_out[2*i+1] === 1'b1 && dr_out[2*i] === 1'b1) begin
                bad++;
                $display("FAIL rail_11: got %h, pair %0d driven 11", dr_out, i);
            end
        end
        dr_prev = dr_out;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Downstream model: acks each phase 3 cycles after dr_out settles; logs dr_out changes.
    task automatic run_downstream(input int n, input int budget);
        logic [7:0] last;
        int cyc;
        seq_q.delete();
        last  = 8'h00;
        cyc   = 0;
        ds_ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (dr_out !== last) begin
                seq_q.push_back(dr_out);
                last = dr_out;
                cyc  = 0;
            end else begin
                cyc++;
            end
            if (cyc == 2) ack_in = (dr_out != 8'h00);
            if (seq_q.size() >= n && !ack_in && dr_out == 8'h00 && !ocupado) begin
                ds_ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        total++; if (dr_out !== 8'h00) begin bad++; $display("FAIL rst_dr: got %h want 00", dr_out); end
        total++; if (hab_out !== 1'b0) begin bad++; $display("FAIL rst_hab: got %b want 0", hab_out); end
        total++; if (pronto_out !== 1'b1) begin bad++; $display("FAIL rst_pronto: got %b want 1", pronto_out); end
        total++; if (erro_timeout !== 1'b0) begin bad++; $display("FAIL rst_erro: got %b want 0", erro_timeout); end
        valido_in = 1'b1;
        dado_in   = 4'hF;
        repeat (3) tick();
        total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL rst_ignore_ocupado: got %b want 0", ocupado); end
        total++; if (dr_out !== 8'h00) begin bad++; $display("FAIL rst_ignore_dr: got %h want 00", dr_out); end
        valido_in = 1'b0;
        rst       = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_single_word();
        dado_in   = 4'b1010;
        valido_in = 1'b1;
        tick();
        valido_in = 1'b0;
        total++; if (dr_out !== 8'h00) begin bad++; $display("FAIL single_lat0: got %h want 00", dr_out); end
        total++; if (ocupado !== 1'b1) begin bad++; $display("FAIL single_ocupado: got %b want 1", ocupado); end
        tick();
        total++; if (dr_out !== 8'b10_01_10_01) begin bad++; $display("FAIL single_dr: got %h want 99", dr_out); end
        total++; if (hab_out !== 1'b1) begin bad++; $display("FAIL single_hab: got %b want 1", hab_out); end
        ack_in = 1'b1;
        tick(); tick();
        total++; if (dr_out !== 8'h99) begin bad++; $display("FAIL single_hold: got %h want 99", dr_out); end
        tick();
        total++; if (dr_out !== 8'h00) begin bad++; $display("FAIL single_spacer: got %h want 00", dr_out); end
        total++; if (hab_out !== 1'b0) begin bad++; $display("FAIL single_hab_off: got %b want 0", hab_out); end
        ack_in = 1'b0;
        tick(); tick();
        total++; if (ocupado !== 1'b1) begin bad++; $display("FAIL single_nulo_busy: got %b want 1", ocupado); end
        tick();
        total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL single_idle: got %b want 0", ocupado); end
        $display("test_single_word done");
    endtask

    task automatic test_back_to_back();
        dado_in   = 4'h3;
        valido_in = 1'b1;
        tick();
        dado_in = 4'hC;
        tick();
        valido_in = 1'b0;
        run_downstream(4, 200);
        total++; if (ds_ok !== 1'b1) begin bad++; $display("FAIL b2b_timeout: got done=%b want 1", ds_ok); end
        total++; if (seq_q.size() != 4) begin bad++; $display("FAIL b2b_len: got %0d want 4", seq_q.size()); end
        else begin
            total++; if (seq_q[0] !== 8'h5A) begin bad++; $display("FAIL b2b_cw3: got %h want 5a", seq_q[0]); end
            total++; if (seq_q[1] !== 8'h00) begin bad++; $display("FAIL b2b_sp1: got %h want 00", seq_q[1]); end
            total++; if (seq_q[2] !== 8'hA5) begin bad++; $display("FAIL b2b_cwC: got %h want a5", seq_q[2]); end
            total++; if (seq_q[3] !== 8'h00) begin bad++; $display("FAIL b2b_sp2: got %h want 00", seq_q[3]); end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_fifo_full();
        ack_in = 1'b1;
        repeat (3) tick();
        dado_in   = 4'h1;
        valido_in = 1'b1;
        tick();
        total++; if (pronto_out !== 1'b1) begin bad++; $display("FAIL full_one: got %b want 1", pronto_out); end
        dado_in = 4'h2;
        tick();
        total++; if (pronto_out !== 1'b0) begin bad++; $display("FAIL full_two: got %b want 0", pronto_out); end
        dado_in = 4'h4;
        tick();
        valido_in = 1'b0;
        total++; if (pronto_out !== 1'b0) begin bad++; $display("FAIL full_reject: got %b want 0", pronto_out); end
        total++; if (dr_out !== 8'h00) begin bad++; $display("FAIL full_dr_idle: got %h want 00", dr_out); end
        run_downstream(4, 300);
        total++; if (ds_ok !== 1'b1) begin bad++; $display("FAIL full_timeout: got done=%b want 1", ds_ok); end
        total++; if (seq_q.size() != 4) begin bad++; $display("FAIL full_len: got %0d want 4", seq_q.size()); end
        else begin
            total++; if (seq_q[0] !== 8'h56) begin bad++; $display("FAIL full_w1: got %h want 56", seq_q[0]); end
            total++; if (seq_q[2] !== 8'h59) begin bad++; $display("FAIL full_w2: got %h want 59", seq_q[2]); end
        end
        $display("test_fifo_full done");
    endtask

    task automatic test_stale_ack();
        ack_in = 1'b1;
        repeat (3) tick();
        dado_in   = 4'h7;
        valido_in = 1'b1;
        tick();
        valido_in = 1'b0;
        repeat (4) tick();
        total++; if (dr_out !== 8'h00) begin bad++; $display("FAIL stale_hold: got %h want 00", dr_out); end
        ack_in = 1'b0;
        tick(); tick();
        total++; if (dr_out !== 8'h00) begin bad++; $display("FAIL stale_sync: got %h want 00", dr_out); end
        tick();
        total++; if (dr_out !== 8'h6A) begin bad++; $display("FAIL stale_cw: got %h want 6a", dr_out); end
        total++; if (hab_out !== 1'b1) begin bad++; $display("FAIL stale_hab: got %b want 1", hab_out); end
        run_downstream(2, 100);
        total++; if (ds_ok !== 1'b1) begin bad++; $display("FAIL stale_finish: got done=%b want 1", ds_ok); end
        $display("test_stale_ack done");
    endtask

    task automatic test_timeout();
        dado_in   = 4'h9;
        valido_in = 1'b1;
        tick();
        valido_in = 1'b0;
        tick();
        total++; if (dr_out !== 8'h96) begin bad++; $display("FAIL to_cw: got %h want 96", dr_out); end
`ifdef CONV_DR_TIMEOUT_EN
        repeat (15) tick();
        total++; if (erro_timeout !== 1'b0) begin bad++; $display("FAIL to_early: got %b want 0", erro_timeout); end
        tick();
        total++; if (erro_timeout !== 1'b1) begin bad++; $display("FAIL to_set: got %b want 1", erro_timeout); end
        run_downstream(2, 100);
        total++; if (erro_timeout !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", erro_timeout); end
        rst = 1'b1;
        #1;
        total++; if (erro_timeout !== 1'b0) begin bad++; $display("FAIL to_clear: got %b want 0", erro_timeout); end
        tick();
        rst = 1'b0;
        tick();
`else
        repeat (20) tick();
        total++; if (erro_timeout !== 1'b0) begin bad++; $display("FAIL to_disabled: got %b want 0", erro_timeout); end
        run_downstream(2, 100);
`endif
        total++; if (ds_ok !== 1'b1) begin bad++; $display("FAIL to_finish: got done=%b want 1", ds_ok); end
        $display("test_timeout done");
    endtask

    task automatic test_reset_mid_traffic();
        dado_in   = 4'h3;
        valido_in = 1'b1;
        tick();
        dado_in = 4'hC;
        tick();
        valido_in = 1'b0;
        total++; if (dr_out !== 8'h5A) begin bad++; $display("FAIL mid_cw: got %h want 5a", dr_out); end
        rst = 1'b1;
        #1;
        total++; if (dr_out !== 8'h00) begin bad++; $display("FAIL mid_dr: got %h want 00", dr_out); end
        total++; if (hab_out !== 1'b0) begin bad++; $display("FAIL mid_hab: got %b want 0", hab_out); end
        total++; if (pronto_out !== 1'b1) begin bad++; $display("FAIL mid_pronto: got %b want 1", pronto_out); end
        total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL mid_ocupado: got %b want 0", ocupado); end
        tick(); tick();
        rst = 1'b0;
        repeat (4) tick();
        total++; if (dr_out !== 8'h00) begin bad++; $display("FAIL mid_flush_dr: got %h want 00", dr_out); end
        total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL mid_flush_busy: got %b want 0", ocupado); end
        $display("test_reset_mid_traffic done");
    endtask

    initial begin
        rst       = 1'b1;
        dado_in   = 4'h0;
        valido_in = 1'b0;
        ack_in    = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_fifo_full();
        test_stale_ack();
        test_timeout();
        test_reset_mid_traffic();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_sinc_dr_4bits.md
Name: conv_sinc_dr_4bits

Overview:
- Clocked-to-dual-rail sender sitting directly upstream of the 4-bit dual-rail asynchronous register.
- Accepts 4-bit single-rail words from the synchronous side via valid/ready and buffers them in a small FIFO.
- Emits each word as an 8-bit dual-rail codeword under a four-phase return-to-zero protocol (DATA, then NULL spacer).
- Drives the register's enable and advances on the downstream completion acknowledge.

Parameters:
- PROF_FIFO, 2: input FIFO depth in words (power of two, >= 2).
- SYNC_ESTAGIOS, 2: flip-flop stages synchronising ack_in (>= 2).
- TIMEOUT_CICLOS, 255: handshake-phase cycle limit before error (only with the optional feature).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- dado_in  input  4  single-rail data word.
- valido_in  input  1  dado_in valid.
- pronto_out  output  1  FIFO can accept a word this cycle.
- dr_out  output  8  dual-rail codeword. Bit i is carried on rails [2i] (false) and [2i+1] (true). 00 = spacer, 01 = logic 0, 10 = logic 1, 11 never driven.
- hab_out  output  1  enable to the downstream register.
- ack_in  input  1  completion acknowledge from downstream detector; asynchronous to clk.
- ocupado  output  1  FSM not in REPOUSO or FIFO non-empty.
- erro_timeout  output  1  sticky handshake-timeout flag.

Interface rule (already decided): one clock; reset is asynchronous and active-high.

Behaviour:
- Reset values, applied immediately on rst: dr_out=8'h00 (spacer), hab_out=0, ocupado=0, erro_timeout=0, FIFO empty, FSM=REPOUSO. Inputs are ignored while rst=1.
- pronto_out = (count < PROF_FIFO), taken from registered count, so it reads 1 while in reset.
- Push: occurs when valido_in & pronto_out at a clock edge. When the FIFO is full, a same-cycle pop does not enable a push (pronto_out stays 0 that cycle).
- ack_s is ack_in after SYNC_ESTAGIOS flops, reset to 0.
- All outputs are registered. dr_out only ever moves spacer->codeword or codeword->spacer, never codeword->codeword, and all rails change in the same cycle.
- FSM states:
  - REPOUSO: dr_out=spacer, hab_out=0. If FIFO non-empty and ack_s=0: pop, load encoded head into dr_out, set hab_out=1, go to DADO.
  - DADO: hold codeword and hab_out=1. When ack_s=1: dr_out=spacer, hab_out=0, go to NULO.
  - NULO: hold spacer. When ack_s=0: if FIFO non-empty, pop and load next codeword with hab_out=1, go to DADO; otherwise go to REPOUSO.
- Latency: a word pushed at edge N into an empty FIFO with FSM in REPOUSO and ack_s=0 appears on dr_out after edge N+1.
- Minimum phase length:
  - Spacer lasts at least SYNC_ESTAGIOS cycles after ack_in falls.
  - Codeword lasts at least SYNC_ESTAGIOS cycles after ack_in rises.
- ack_s=1 observed in REPOUSO means a stale acknowledge: stay in REPOUSO until it falls.
- Reset mid-operation: the spacer is forced asynchronously, which is a legal return-to-NULL for downstream. The FIFO is flushed and in-flight words are discarded.
- FIFO pointers wrap modulo PROF_FIFO; count is $clog2(PROF_FIFO)+1 bits wide.

Optional Feature:
- Macro CONV_DR_TIMEOUT_EN.
- Defined:
  - An 8-bit-min cycle counter clears on every state entry and increments in DADO and NULO.
  - Reaching TIMEOUT_CICLOS sets erro_timeout=1, which holds until rst.
  - The FSM keeps waiting; data is not dropped.
- Undefined: no counter; erro_timeout is tied to 0.

Decomposition:
- Shared package conv_dr_pkg:
  - FSM state enum {REPOUSO, DADO, NULO}.
  - DR_ESPACADOR=8'h00.
  - Function cod_dual_rail(4-bit) returning 8 bits, shared with the dual-rail completion/decoder blocks.
- One natural sub-module: sinc_ack, an N-stage synchroniser with async reset.

Test Plan:
- Reset during traffic: assert rst while dr_out=8'h5A (codeword) -> dr_out=8'h00, hab_out=0, pronto_out=1 with no clock edge needed.
- Single word: push 4'b1010 with ack_in tied low -> next cycle dr_out=8'b10_01_10_01 and hab_out=1. Raise ack_in -> dr_out=00 and hab_out=0 exactly SYNC_ESTAGIOS+1 edges later. Drop ack_in -> FSM returns to REPOUSO and ocupado=0.
- Back-to-back: push 4'h3, 4'hC, with a downstream model acking each phase after 3 cycles -> dr_out sequence 0x55-ish codeword for 3, spacer, codeword for C, spacer, with no direct codeword->codeword transition (assertion).
- FIFO full: with ack_in stuck high, push 3 words into PROF_FIFO=2 -> third push rejected (pronto_out=0) and FIFO contents intact after ack is released.
- Stale ack: ack_in=1 in REPOUSO, push 4'h7 -> dr_out stays 00 until ack_in=0, then the codeword appears.
- CONV_DR_TIMEOUT_EN with TIMEOUT_CICLOS=16: hold ack_in=0 in DADO -> erro_timeout=1 at cycle 16. It remains set after the ack completes, and clears only on rst.
